scoreboard_ram_arbiter: RTL and testbench
=========================================

# scoreboard_ram_arbiter

Sequences the single-port scoreboard RAM and shares it between two requesters: the score-update writer (scoreboard logic) and the display reader (scoreboard display). It also owns a clear engine that zero-fills the table after a reset or a new-game request. It sits between both requesters and the RAM, and is the only block that drives the RAM address, data and write-enable ports.

## Interface
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width
- CLR_DEPTH, 256, number of entries zeroed by a clear sweep, starting at address 0
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- wr_req  input  1  writer request; held high until wr_gnt
- wr_addr  input  ADDR_W  write address; stable while wr_req is high
- wr_data  input  DATA_W  write data; stable while wr_req is high
- wr_gnt  output  1  one-cycle pulse in the cycle the write is driven to RAM
- rd_req  input  1  reader request; held high until rd_gnt
- rd_addr  input  ADDR_W  read address; stable while rd_req is high
- rd_gnt  output  1  one-cycle pulse in the cycle the read address is driven to RAM
- rd_valid  output  1  one-cycle pulse when rd_data is valid
- rd_data  output  DATA_W  registered read data; holds its value until the next rd_valid
- clr_start  input  1  pulse that requests a clear sweep
- clr_busy  output  1  high while the sweep runs
- clr_done  output  1  one-cycle pulse after the last clear write
- ram_address  output  ADDR_W  to RAM address port
- ram_data_in  output  DATA_W  to RAM data input
- ram_wren  output  1  to RAM write enable
- ram_data_out  input  DATA_W  from RAM data output

## Operation
- RAM contract: RAM samples address, data and wren on the rising edge. Read data appears on ram_data_out in the cycle after the address cycle.
- All outputs are registered.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_CAPTURE, CLEAR.
- IDLE decides in priority order:
  - pending clear first, go to CLEAR;
  - otherwise a single request goes to WR_ISSUE or RD_ISSUE;
  - simultaneous wr_req and rd_req are resolved per Configuration.
- WR_ISSUE (one cycle):
  - drives ram_wren=1, ram_address=wr_addr, ram_data_in=wr_data, and wr_gnt=1;
  - goes to IDLE.
- RD_ISSUE:
  - drives ram_wren=0, ram_address=rd_addr, and rd_gnt=1;
  - then RD_WAIT (RAM latency), then RD_CAPTURE.
- RD_CAPTURE: registers ram_data_out into rd_data, pulses rd_valid, goes to IDLE.
- CLEAR:
  - writes 0 to addresses 0..CLR_DEPTH-1, one per cycle, with ram_wren=1 and clr_busy=1;
  - after address CLR_DEPTH-1 it pulses clr_done and goes to IDLE.
- Clear pending latch:
  - clr_start in any non-CLEAR state sets it; the current read or write completes first.
  - clr_start during CLEAR is ignored; the sweep does not restart.
- Requests during CLEAR are stalled: no grants are issued until IDLE.
- Outside WR_ISSUE and CLEAR, ram_wren is 0 and ram_address and ram_data_in hold their last value.
- Clear address counter: ADDR_W bits. CLR_DEPTH must be at most 2^ADDR_W and is checked at elaboration.
- Reset asserted mid-operation aborts at once:
  - the FSM returns to IDLE and the pending clear latch is cleared;
  - a partial sweep is not resumed;
  - no rd_valid is produced for an aborted read.

## Timing
- Reset values: wr_gnt, rd_gnt, rd_valid, clr_busy, clr_done and ram_wren are 0; ram_address, ram_data_in and rd_data are 0; state is IDLE.
- Write: wr_req seen in IDLE at cycle t, so wr_gnt and the RAM write occur at t+1. The earliest next grant is t+3.
- Read: rd_req seen at cycle t gives rd_gnt at t+1 and rd_valid with rd_data at t+3. The earliest next grant is t+5.
- Clear: clr_start seen at cycle t in IDLE gives clr_busy from t+1 through t+CLR_DEPTH and clr_done at t+CLR_DEPTH+1.
- A requester may deassert req in the cycle after its gnt. A request still high after its gnt is treated as a new request.

## Configuration
- SB_ARB_RR_EN defined: simultaneous requests are served round-robin.
  - A one-bit last-served pointer grants the requester not served most recently.
  - The pointer resets to "writer last", so the reader wins the first tie.
- SB_ARB_RR_EN undefined: fixed priority, the writer always wins ties. The pointer logic is absent.

## Structure
- Shared scoreboard_pkg holds:
  - the state enum;
  - the default ADDR_W and DATA_W constants;
  - the clear fill value, all-zero constant.
- One sub-module: sb_clear_sweeper, containing the address counter, terminal-count detect and done pulse. It is enabled by the FSM while in CLEAR.

## Test plan
- Reset, then wr_req with addr 0x0005, data 0x1234 -> wr_gnt and ram_wren at t+1 with ram_address 0x0005; a later read of 0x0005 returns rd_data 0x1234 at rd_gnt+2.
- wr_req and rd_req raised in the same cycle, repeated 4 times:
  - fixed mode -> the writer is granted every time;
  - SB_ARB_RR_EN -> grants go reader, writer, reader, writer.
- clr_start in IDLE with CLR_DEPTH=8 -> clr_busy for 8 cycles, addresses 0..7 written with 0, clr_done one cycle after address 7; reading address 7 then returns 0x0000.
- clr_start during RD_WAIT -> rd_valid still delivered, then CLEAR starts; an rd_req raised during CLEAR gets no rd_gnt until after clr_done.
- rst asserted in the 4th cycle of a CLR_DEPTH=8 sweep -> all outputs 0 immediately, clr_done never pulses, the FSM is IDLE after release.
- clr_start pulsed again mid-sweep -> the sweep length is still exactly CLR_DEPTH writes and only one clr_done pulse occurs.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared state type and constants for the scoreboard RAM arbiter
package scoreboard_pkg;

   localparam int SB_ADDR_W = 16;
   localparam int SB_DATA_W = 16;

   localparam logic [SB_DATA_W-1:0] SB_CLR_FILL = '0;

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      RD_ISSUE,
      RD_WAIT,
      RD_CAPTURE,
      CLEAR
   } sb_state_e;

endpackage

// File: rtl/sb_clear_sweeper.sv
// rtl/sb_clear_sweeper.sv - clear sweep address counter, terminal-count detect and done pulse
module sb_clear_sweeper import scoreboard_pkg::*; #(
   parameter int ADDR_W    = SB_ADDR_W,
   parameter int CLR_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              en,
   output logic [ADDR_W-1:0] next_addr,
   output logic              last,
   output logic              done
);

   if (CLR_DEPTH < 1 || longint'(CLR_DEPTH) > (longint'(1) << ADDR_W)) begin : g_depth_check
      $error("sb_clear_sweeper: CLR_DEPTH must be in 1..2**ADDR_W");
   end

   // Counter runs one ahead of the address on the RAM port, so it reaches
   // CLR_DEPTH (mod 2**ADDR_W) exactly while the final entry is being written.
   localparam logic [ADDR_W-1:0] TERM = ADDR_W'(CLR_DEPTH);

   logic [ADDR_W-1:0] cnt;

   assign next_addr = cnt;
   assign last      = (cnt == TERM);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= en && last;
         if (start) begin
            cnt <= ADDR_W'(1);
         end else if (en) begin
            cnt <= cnt + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/scoreboard_ram_arbiter.sv
// rtl/scoreboard_ram_arbiter.sv - single-port scoreboard RAM sequencer with writer/reader arbitration and clear engine
// SB_ARB_RR_EN selects round-robin tie resolution; otherwise the writer wins ties.
module scoreboard_ram_arbiter import scoreboard_pkg::*; #(
   parameter int ADDR_W    = SB_ADDR_W,
   parameter int DATA_W    = SB_DATA_W,
   parameter int CLR_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_data_out
);

   sb_state_e         state;
   logic              clr_pend;
   logic              sweep_start;
   logic              sweep_en;
   logic              sweep_last;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_wins_tie;
   logic              pick_wr;
   logic              pick_rd;

`ifdef SB_ARB_RR_EN
   logic last_wr;
   assign wr_wins_tie = !last_wr;
`else
   assign wr_wins_tie = 1'b1;
`endif

   assign pick_wr     = wr_req && (!rd_req || wr_wins_tie);
   assign pick_rd     = rd_req && !pick_wr;
   assign sweep_start = (state == IDLE) && (clr_pend || clr_start);
   assign sweep_en    = (state == CLEAR);

   sb_clear_sweeper #(
      .ADDR_W    (ADDR_W),
      .CLR_DEPTH (CLR_DEPTH)
   ) u_sweeper (
      .clk       (clk),
      .rst       (rst),
      .start     (sweep_start),
      .en        (sweep_en),
      .next_addr (sweep_addr),
      .last      (sweep_last),
      .done      (clr_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         clr_pend    <= 1'b0;
         wr_gnt      <= 1'b0;
         rd_gnt      <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         clr_busy    <= 1'b0;
         ram_wren    <= 1'b0;
         ram_address <= '0;
         ram_data_in <= '0;
`ifdef SB_ARB_RR_EN
         last_wr     <= 1'b1;
`endif
      end else begin
         wr_gnt   <= 1'b0;
         rd_gnt   <= 1'b0;
         rd_valid <= 1'b0;
         ram_wren <= 1'b0;
         // A clear arriving mid-transaction waits for that transaction to finish.
         if (clr_start && state != CLEAR) begin
            clr_pend <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (clr_pend || clr_start) begin
                  state       <= CLEAR;
                  clr_pend    <= 1'b0;
                  clr_busy    <= 1'b1;
                  ram_wren    <= 1'b1;
                  ram_address <= '0;
                  ram_data_in <= DATA_W'(SB_CLR_FILL);
               end else if (pick_wr) begin
                  state       <= WR_ISSUE;
                  wr_gnt      <= 1'b1;
                  ram_wren    <= 1'b1;
                  ram_address <= wr_addr;
                  ram_data_in <= wr_data;
`ifdef SB_ARB_RR_EN
                  last_wr     <= 1'b1;
`endif
               end else if (pick_rd) begin
                  state       <= RD_ISSUE;
                  rd_gnt      <= 1'b1;
                  ram_address <= rd_addr;
`ifdef SB_ARB_RR_EN
                  last_wr     <= 1'b0;
`endif
               end
            end
            WR_ISSUE: state <= IDLE;
            RD_ISSUE: state <= RD_WAIT;
            RD_WAIT: begin
               state    <= RD_CAPTURE;
               rd_data  <= ram_data_out;
               rd_valid <= 1'b1;
            end
            RD_CAPTURE: state <= IDLE;
            CLEAR: begin
               if (sweep_last) begin
                  state    <= IDLE;
                  clr_busy <= 1'b0;
               end else begin
                  ram_wren    <= 1'b1;
                  ram_address <= sweep_addr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scoreboard_ram_arbiter.sv
// tb/tb_scoreboard_ram_arbiter.sv - self-checking bench for scoreboard_ram_arbiter with CLR_DEPTH=8
// Tie expectations follow SB_ARB_RR_EN when it is defined.
module tb_scoreboard_ram_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_gnt;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_gnt;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          clr_start = 1'b0;
   logic          clr_busy;
   logic          clr_done;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic          ram_wren;
   logic [DW-1:0] ram_data_out = '0;

   int errors = 0;
   int checks = 0;
   bit model_last_wr = 1'b1;

   logic [DW-1:0] ram_mem [0:65535];
   logic [DW-1:0] exp_mem [0:65535];

   always #5 clk = ~clk;

   scoreboard_ram_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .CLR_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_gnt       (wr_gnt),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_gnt       (rd_gnt),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .clr_start    (clr_start),
      .clr_busy     (clr_busy),
      .clr_done     (clr_done),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_wren     (ram_wren),
      .ram_data_out (ram_data_out)
   );

   // Synchronous single-port RAM: read data one cycle after the address cycle.
   always @(posedge clk) begin
      if (ram_wren) ram_mem[ram_address] <= ram_data_in;
      ram_data_out <= ram_mem[ram_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, {wr_gnt, rd_gnt, rd_valid, clr_busy, clr_done, ram_wren}, 0);
      check({tag, "_ram_address"}, ram_address, 0);
      check({tag, "_ram_data_in"}, ram_data_in, 0);
      check({tag, "_rd_data"}, rd_data, 0);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      do begin tick(); n++; end while (!wr_gnt && n < 30);
      check("wr_latency", n, 1);
      check("wr_wren", ram_wren, 1);
      check("wr_ram_address", ram_address, a);
      check("wr_ram_data_in", ram_data_in, d);
      wr_req = 1'b0;
      exp_mem[a] = d;
      model_last_wr = 1'b1;
      tick();
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      int n = 0;
      rd_req = 1'b1; rd_addr = a;
      do begin tick(); n++; end while (!rd_gnt && n < 30);
      check("rd_latency", n, 1);
      check("rd_issue_addr_wren", {ram_wren, ram_address}, {1'b0, a});
      rd_req = 1'b0;
      model_last_wr = 1'b0;
      tick();
      check("rd_valid_early", rd_valid, 0);
      tick();
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, exp_mem[a]);
      tick();
      check("rd_data_hold", {rd_valid, rd_data}, {1'b0, exp_mem[a]});
   endtask

   task automatic do_clear(input int repulse_at);
      int n_wr = 0, n_busy = 0, n_done = 0, done_at = -1, last_at = -1, bad = 0;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ram_wren) begin
            if (ram_address !== n_wr[AW-1:0] || ram_data_in !== '0) bad++;
            n_wr++;
            last_at = i;
         end
         if (clr_busy) n_busy++;
         if (clr_done) begin n_done++; done_at = i; end
         clr_start = (i == repulse_at);
         tick();
      end
      clr_start = 1'b0;
      check("clr_writes", n_wr, DEPTH);
      check("clr_busy_cycles", n_busy, DEPTH);
      check("clr_addr_data_seq", bad, 0);
      check("clr_last_write_at", last_at, DEPTH - 1);
      check("clr_done_count", n_done, 1);
      check("clr_done_at", done_at, DEPTH);
      for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]    wpat;
      logic [4:0]    gpat, vpat;
      logic [DW-1:0] got, wd;
      logic [AW-1:0] ra;
      bit            exp_w;
      int            done_at, gnt_at, cnt_done, cnt_busy, cnt_wren;

      for (int a = 0; a < 65536; a++) begin
         ram_mem[a] = '0;
         exp_mem[a] = '0;
      end

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b1;
      tick();

      // Basic write then read-back
      do_write(16'h0005, 16'h1234);

      // Write request held high: grants at t+1 and t+3
      wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'hAAAA; wpat = '0;
      for (int i = 0; i < 3; i++) begin tick(); wpat = {wpat[1:0], wr_gnt}; end
      check("wr_held_gnt_pattern", wpat, 3'b101);
      wr_req = 1'b0;
      exp_mem[16'h0010] = 16'hAAAA;
      model_last_wr = 1'b1;
      tick();

      // Read request held high: grants at t+1 and t+5, data at t+3
      rd_req = 1'b1; rd_addr = 16'h0005; gpat = '0; vpat = '0; got = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         gpat = {gpat[3:0], rd_gnt};
         vpat = {vpat[3:0], rd_valid};
         if (rd_valid) got = rd_data;
      end
      check("rd_held_gnt_pattern", gpat, 5'b10001);
      check("rd_held_valid_pattern", vpat, 5'b00100);
      check("rd_first_data", got, 16'h1234);
      rd_req = 1'b0;
      model_last_wr = 1'b0;
      tick();
      tick();
      check("rd_second_data", {rd_valid, rd_data}, {1'b1, 16'h1234});
      tick();

      do_write(16'h0007, 16'hBEEF);
      do_write(16'h0020, 16'($urandom));

      // Simultaneous requests, four fresh ties
      for (int i = 0; i < 4; i++) begin
`ifdef SB_ARB_RR_EN
         exp_w = !model_last_wr;
`else
         exp_w = 1'b1;
`endif
         wd = 16'($urandom);
         wr_req = 1'b1; rd_req = 1'b1;
         wr_addr = 16'h0040 + 16'(i); wr_data = wd; rd_addr = 16'h0020;
         tick();
         check("tie_gnts", {wr_gnt, rd_gnt}, {exp_w, !exp_w});
         wr_req = 1'b0; rd_req = 1'b0;
         if (exp_w) begin
            exp_mem[16'h0040 + 16'(i)] = wd;
            model_last_wr = 1'b1;
            tick();
         end else begin
            model_last_wr = 1'b0;
            tick();
            tick();
            check("tie_rd_data", {rd_valid, rd_data}, {1'b1, exp_mem[16'h0020]});
            tick();
         end
      end

      // Clear sweep from IDLE, then confirm entry 7 is zero and 0x20 untouched
      do_clear(-1);
      do_read(16'h0007);
      do_read(16'h0020);

      // Clear requested during RD_WAIT; read completes, reader then stalls
      do_write(16'h0030, 16'hC0DE);
      rd_req = 1'b1; rd_addr = 16'h0030;
      tick();
      check("rdw_gnt", rd_gnt, 1);
      rd_req = 1'b0;
      tick();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      check("rdw_valid_data", {rd_valid, rd_data}, {1'b1, 16'hC0DE});
      model_last_wr = 1'b0;
      tick();
      check("rdw_idle_before_clear", clr_busy, 0);
      tick();
      check("rdw_clear_started", {clr_busy, ram_wren, ram_address}, {2'b11, 16'h0000});
      rd_req = 1'b1; rd_addr = 16'h0003;
      done_at = -1; gnt_at = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (clr_done) done_at = i;
         if (rd_gnt) begin gnt_at = i; break; end
      end
      for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
      check("rdw_done_at", done_at, DEPTH - 1);
      check("rdw_gnt_after_done", gnt_at, done_at + 1);
      rd_req = 1'b0;
      model_last_wr = 1'b0;
      tick();
      tick();
      check("rdw_cleared_data", {rd_valid, rd_data}, {1'b1, 16'h0000});
      tick();

      // Reset asserted in the 4th sweep cycle
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_all_zero("mid_sweep_rst");
      tick();
      rst = 1'b1;
      model_last_wr = 1'b1;
      cnt_done = 0; cnt_busy = 0; cnt_wren = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (clr_done) cnt_done++;
         if (clr_busy) cnt_busy++;
         if (ram_wren) cnt_wren++;
      end
      check("post_rst_activity", {cnt_done[7:0], cnt_busy[7:0], cnt_wren[7:0]}, 0);
      do_write(16'h0050, 16'h5A5A);

      // Second clr_start pulse mid-sweep is ignored
      do_clear(3);

      // Random mixed traffic against the memory model
      for (int k = 0; k < 40; k++) begin
         ra = 16'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) tick();
         if ($urandom_range(0, 1) == 1) do_write(ra, 16'($urandom));
         else do_read(ra);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
